// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: geometry, FSM encodings and the tag parity helper.
package icache_pkg;

    localparam int ICACHE_INDEX_BITS  = 6;
    localparam int ICACHE_OFFSET_BITS = 2;

    localparam logic [1:0] ICACHE_IDLE    = 2'd0;
    localparam logic [1:0] ICACHE_REFILL  = 2'd1;
    localparam logic [1:0] ICACHE_RESPOND = 2'd2;

    typedef logic [1:0] icache_state_t;

    // Even parity over a zero-extended tag; a stored mismatch is treated as a miss.
    function automatic logic tag_parity(input logic [31:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and refill-side handshake signals of the instruction cache.
interface icache_if;
    logic        to_icache;
    logic [31:0] pc_to_icache;
    logic        have_result;
    logic [31:0] inst_from_icache;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport slave (
        input  to_icache, pc_to_icache, mem_done, mem_data,
        output have_result, inst_from_icache, mem_req, mem_addr
    );

    modport master (
        output to_icache, pc_to_icache, mem_done, mem_data,
        input  have_result, inst_from_icache, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_array.sv
// Storage for the direct-mapped cache: data words, tags with parity, and valid bits.
// Writes are synchronous, reads are combinational; only the valid bits are reset.
module icache_array #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_BITS    = 22
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              data_we_in,
    input  logic [INDEX_BITS+OFFSET_BITS-1:0] data_waddr_in,
    input  logic [31:0]                       data_wdata_in,
    input  logic                              tag_we_in,
    input  logic [INDEX_BITS-1:0]             tag_widx_in,
    input  logic [TAG_BITS:0]                 tag_wdata_in,
    input  logic [INDEX_BITS-1:0]             rd_idx_in,
    input  logic [OFFSET_BITS-1:0]            rd_off_in,
    output logic [31:0]                       rd_data_out,
    output logic [TAG_BITS-1:0]               rd_tag_out,
    output logic                              rd_tpar_out,
    output logic                              rd_valid_out
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << (INDEX_BITS + OFFSET_BITS);

    logic [31:0]       data_mem_q [WORDS];
    logic [TAG_BITS:0] tag_mem_q  [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;

    // A line becomes valid only together with its tag write.
    always_comb begin
        valid_d = valid_q;
        if (tag_we_in) begin
            valid_d[tag_widx_in] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits, cleared asynchronously so a partial refill never survives reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= {LINES{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data and tag RAM write ports.
    always_ff @(posedge clk_in) begin
        if (data_we_in) begin
            data_mem_q[data_waddr_in] <= data_wdata_in;
        end
        if (tag_we_in) begin
            tag_mem_q[tag_widx_in] <= tag_wdata_in;
        end
    end

    assign rd_data_out  = data_mem_q[{rd_idx_in, rd_off_in}];
    assign rd_tag_out   = tag_mem_q[rd_idx_in][TAG_BITS-1:0];
    assign rd_tpar_out  = tag_mem_q[rd_idx_in][TAG_BITS];
    assign rd_valid_out = valid_q[rd_idx_in];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between ifetch and memctrl.
// Misses refill a whole line word by word (0..N-1) and then answer from the array.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
    parameter int OFFSET_BITS = ICACHE_OFFSET_BITS
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    rdy_in,
    icache_if.slave bus
);
    localparam int TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;
    localparam int TAG_BITS = 32 - TAG_LSB;
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = {OFFSET_BITS{1'b1}};

    icache_state_t          state_q, state_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic [31:0]            req_pc_q, req_pc_d;
    logic                   have_result_q, have_result_d;
    logic [31:0]            inst_q, inst_d;
    logic                   mem_req_q, mem_req_d;
    logic [31:0]            mem_addr_q, mem_addr_d;

    logic [INDEX_BITS-1:0]  pc_idx_s, req_idx_s, rd_idx_s;
    logic [OFFSET_BITS-1:0] pc_off_s, req_off_s, rd_off_s;
    logic [TAG_BITS-1:0]    pc_tag_s, req_tag_s, rd_tag_s;
    logic [31:0]            rd_data_s;
    logic                   rd_tpar_s;
    logic                   rd_valid_s;
    logic                   hit_s;
    logic                   data_we_s;
    logic                   tag_we_s;
    logic                   unused_s;

    assign pc_tag_s  = bus.pc_to_icache[31:TAG_LSB];
    assign pc_idx_s  = bus.pc_to_icache[TAG_LSB-1:OFFSET_BITS+2];
    assign pc_off_s  = bus.pc_to_icache[OFFSET_BITS+1:2];
    assign req_tag_s = req_pc_q[31:TAG_LSB];
    assign req_idx_s = req_pc_q[TAG_LSB-1:OFFSET_BITS+2];
    assign req_off_s = req_pc_q[OFFSET_BITS+1:2];
    assign unused_s  = ^{bus.pc_to_icache[1:0], req_pc_q[1:0]};

    icache_array #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_BITS    (TAG_BITS)
    ) u_array (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .data_we_in    (data_we_s),
        .data_waddr_in ({req_idx_s, cnt_q}),
        .data_wdata_in (bus.mem_data),
        .tag_we_in     (tag_we_s),
        .tag_widx_in   (req_idx_s),
        .tag_wdata_in  ({tag_parity(32'(req_tag_s)), req_tag_s}),
        .rd_idx_in     (rd_idx_s),
        .rd_off_in     (rd_off_s),
        .rd_data_out   (rd_data_s),
        .rd_tag_out    (rd_tag_s),
        .rd_tpar_out   (rd_tpar_s),
        .rd_valid_out  (rd_valid_s)
    );

    // Lookups use the live pc in IDLE and the latched miss address otherwise.
    always_comb begin
        rd_idx_s = req_idx_s;
        rd_off_s = req_off_s;
        if (state_q == ICACHE_IDLE) begin
            rd_idx_s = pc_idx_s;
            rd_off_s = pc_off_s;
        end else begin
            rd_idx_s = req_idx_s;
            rd_off_s = req_off_s;
        end
        hit_s = rd_valid_s && (rd_tag_s == pc_tag_s)
                && (rd_tpar_s == tag_parity(32'(rd_tag_s)));
    end

    // Next-state logic; with rdy_in low every register and array port holds.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_pc_d      = req_pc_q;
        have_result_d = 1'b0;
        inst_d        = inst_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        data_we_s     = 1'b0;
        tag_we_s      = 1'b0;
        if (!rdy_in) begin
            have_result_d = have_result_q;
        end else begin
            case (state_q)
                ICACHE_IDLE: begin
                    if (bus.to_icache && hit_s) begin
                        have_result_d = 1'b1;
                        inst_d        = rd_data_s;
                    end else if (bus.to_icache) begin
                        req_pc_d   = bus.pc_to_icache;
                        cnt_d      = {OFFSET_BITS{1'b0}};
                        mem_req_d  = 1'b1;
                        mem_addr_d = {bus.pc_to_icache[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
                        state_d    = ICACHE_REFILL;
                    end else begin
                        state_d = ICACHE_IDLE;
                    end
                end
                ICACHE_REFILL: begin
                    if (bus.mem_done) begin
                        data_we_s = 1'b1;
                        if (cnt_q == LAST_WORD) begin
                            tag_we_s  = 1'b1;
                            mem_req_d = 1'b0;
                            cnt_d     = {OFFSET_BITS{1'b0}};
                            state_d   = ICACHE_RESPOND;
                        end else begin
                            cnt_d      = cnt_q + OFFSET_BITS'(1);
                            mem_addr_d = mem_addr_q + 32'd4;
                        end
                    end else begin
                        state_d = ICACHE_REFILL;
                    end
                end
                ICACHE_RESPOND: begin
                    have_result_d = 1'b1;
                    inst_d        = rd_data_s;
                    state_d       = ICACHE_IDLE;
                end
                default: begin
                    mem_req_d = 1'b0;
                    state_d   = ICACHE_IDLE;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ICACHE_IDLE;
            cnt_q         <= {OFFSET_BITS{1'b0}};
            req_pc_q      <= 32'd0;
            have_result_q <= 1'b0;
            inst_q        <= 32'd0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_pc_q      <= req_pc_d;
            have_result_q <= have_result_d;
            inst_q        <= inst_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    assign bus.have_result      = have_result_q;
    assign bus.inst_from_icache = inst_q;
    assign bus.mem_req          = mem_req_q;
    assign bus.mem_addr         = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed and randomized fetches against a line-level cache model and a behavioural memctrl.
module tb_icache;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    icache_if bus ();

    icache dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          lat   = 3;
    int          wcnt  = 0;
    logic [31:0] addr_log [$];
    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    logic        r_e, s_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // memctrl: answers each word after lat idle cycles and holds mem_done until taken with rdy high
    initial begin
        bus.mem_done = 1'b0;
        bus.mem_data = 32'd0;
        forever begin
            @(posedge clk);
            r_e = rdy;
            s_e = rst;
            #1;
            if (s_e || rst) begin
                bus.mem_done = 1'b0;
                wcnt = 0;
            end else if (bus.mem_done) begin
                if (r_e) bus.mem_done = 1'b0;
            end else if (bus.mem_req) begin
                if (wcnt >= lat) begin
                    bus.mem_done = 1'b1;
                    bus.mem_data = mem_word(bus.mem_addr);
                    addr_log.push_back(bus.mem_addr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        chk({name, "/rst_mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({name, "/rst_have_result"}, 32'(bus.have_result), 32'd0);
        chk({name, "/rst_inst"}, bus.inst_from_icache, 32'd0);
        chk({name, "/rst_mem_addr"}, bus.mem_addr, 32'd0);
        tick;
        tick;
        rst = 1'b0;
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        addr_log.delete();
    endtask

    task automatic start_fetch(input logic [31:0] pc, output int nlog0, output bit exp_hit);
        nlog0   = addr_log.size();
        exp_hit = m_valid[pc[9:4]] && (m_tag[pc[9:4]] == pc[31:10]);
        bus.pc_to_icache = pc;
        bus.to_icache    = 1'b1;
        tick;
        bus.to_icache    = 1'b0;
    endtask

    task automatic finish_fetch(input logic [31:0] pc, input string name, input int nlog0,
                                input bit exp_hit);
        int          cyc;
        int          nw;
        logic [31:0] base;
        base = {pc[31:4], 4'h0};
        cyc  = 1;
        while (bus.have_result !== 1'b1 && cyc < 300) begin
            tick;
            cyc++;
        end
        chk({name, "/have_result"}, 32'(bus.have_result), 32'd1);
        chk({name, "/inst"}, bus.inst_from_icache, mem_word({pc[31:2], 2'b00}));
        chk({name, "/mem_req_low"}, 32'(bus.mem_req), 32'd0);
        nw = addr_log.size() - nlog0;
        if (exp_hit) begin
            chk({name, "/hit_latency"}, 32'(cyc), 32'd1);
            chk({name, "/hit_no_refill"}, 32'(nw), 32'd0);
        end else begin
            chk({name, "/miss_slow"}, 32'(cyc > 4), 32'd1);
            chk({name, "/refill_words"}, 32'(nw), 32'd4);
            for (int k = 0; k < 4; k++) begin
                if (nlog0 + k < addr_log.size())
                    chk({name, "/refill_addr"}, addr_log[nlog0 + k], base + 32'(4 * k));
            end
            m_valid[pc[9:4]] = 1'b1;
            m_tag[pc[9:4]]   = pc[31:10];
        end
        tick;
        chk({name, "/pulse"}, 32'(bus.have_result), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] pc, input string name);
        int n0;
        bit eh;
        start_fetch(pc, n0, eh);
        finish_fetch(pc, name, n0, eh);
    endtask

    task automatic wait_words(input int target);
        int wt;
        wt = 0;
        while (!(addr_log.size() >= target && bus.mem_done) && wt < 200) begin
            tick;
            wt++;
        end
        chk("wait_words", 32'(addr_log.size() >= target), 32'd1);
    endtask

    initial begin
        int          n0;
        bit          eh;
        logic [31:0] pc;
        rst = 1'b0;
        rdy = 1'b1;
        bus.to_icache    = 1'b0;
        bus.pc_to_icache = 32'd0;
        tick;
        do_reset("reset");

        lat = 3;
        fetch(32'h0000_0000, "cold_miss");
        fetch(32'h0000_0008, "hit");
        fetch(32'h0000_0400, "conflict");
        fetch(32'h0000_0000, "conflict_back");

        start_fetch(32'h0000_0104, n0, eh);
        wait_words(n0 + 2);
        chk("freeze/pending_addr", bus.mem_addr, 32'h0000_0104);
        rdy = 1'b0;
        repeat (5) begin
            tick;
            chk("freeze/mem_addr", bus.mem_addr, 32'h0000_0104);
            chk("freeze/no_advance", 32'(addr_log.size() - n0), 32'd2);
            chk("freeze/no_result", 32'(bus.have_result), 32'd0);
        end
        rdy = 1'b1;
        finish_fetch(32'h0000_0104, "freeze", n0, eh);

        start_fetch(32'h0000_0208, n0, eh);
        wait_words(n0 + 2);
        tick;
        do_reset("mid_refill_reset");
        fetch(32'h0000_0208, "after_reset");

        lat = 1;
        start_fetch(32'h0000_0300, n0, eh);
        tick;
        tick;
        bus.pc_to_icache = 32'h0000_0208;
        bus.to_icache    = 1'b1;
        tick;
        bus.to_icache    = 1'b0;
        finish_fetch(32'h0000_0300, "ignored_req", n0, eh);
        repeat (6) begin
            tick;
            chk("ignored_req/no_extra", 32'(bus.have_result), 32'd0);
        end

        fetch(32'hFFFF_FFFC, "wrap_miss");
        fetch(32'hFFFF_FFF1, "wrap_hit");

        for (int i = 0; i < 40; i++) begin
            lat = $urandom_range(0, 3);
            pc  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
                | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            fetch(pc, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
